// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sound path.
// Holds the note record, melody IDs, scheduler state encoding and the
// melody ROM (4 melodies x 8 notes, {freq, dur_ms}; dur_ms == 0 ends a melody,
// freq == 0 is a rest).
package simon_pkg;

  typedef struct packed {
    logic [9:0] freq;
    logic [9:0] dur;
  } note_t;

  localparam logic [1:0] MEL_SUCCESS  = 2'd0;
  localparam logic [1:0] MEL_GAMEOVER = 2'd1;
  localparam logic [1:0] MEL_CHIME    = 2'd2;
  localparam logic [1:0] MEL_CLICK    = 2'd3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_NOTE   = 3'd2;
  localparam logic [2:0] ST_GAP    = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  localparam logic [9:0] DUR_SUCCESS  = 10'd150;
  localparam logic [9:0] DUR_GAMEOVER = 10'd300;
  localparam logic [9:0] DUR_CHIME    = 10'd100;
  localparam logic [9:0] DUR_CLICK    = 10'd50;

  // Unlisted slots read as the end marker.
  function automatic note_t rom_note(input logic [1:0] mel, input logic [2:0] idx);
    note_t n;
    n = '0;
    case ({mel, idx})
      {MEL_SUCCESS,  3'd0}: n = '{freq: 10'd330, dur: DUR_SUCCESS};
      {MEL_SUCCESS,  3'd1}: n = '{freq: 10'd392, dur: DUR_SUCCESS};
      {MEL_SUCCESS,  3'd2}: n = '{freq: 10'd659, dur: DUR_SUCCESS};
      {MEL_SUCCESS,  3'd3}: n = '{freq: 10'd523, dur: DUR_SUCCESS};
      {MEL_SUCCESS,  3'd4}: n = '{freq: 10'd587, dur: DUR_SUCCESS};
      {MEL_SUCCESS,  3'd5}: n = '{freq: 10'd784, dur: DUR_SUCCESS};
      {MEL_GAMEOVER, 3'd0}: n = '{freq: 10'd622, dur: DUR_GAMEOVER};
      {MEL_GAMEOVER, 3'd1}: n = '{freq: 10'd587, dur: DUR_GAMEOVER};
      {MEL_GAMEOVER, 3'd2}: n = '{freq: 10'd554, dur: DUR_GAMEOVER};
      {MEL_GAMEOVER, 3'd3}: n = '{freq: 10'd523, dur: DUR_GAMEOVER};
      {MEL_CHIME,    3'd0}: n = '{freq: 10'd196, dur: DUR_CHIME};
      {MEL_CHIME,    3'd1}: n = '{freq: 10'd784, dur: DUR_CHIME};
      {MEL_CLICK,    3'd0}: n = '{freq: 10'd262, dur: DUR_CLICK};
      default:              n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tone_scheduler_ms_prescaler.sv
// Millisecond prescaler.
//   clk, rst_n       : clock, async active-low reset
//   clr              : synchronous restart of the count
//   ticks_per_milli  : cycles per ms (0 behaves as 1)
//   ms_tick          : 1-cycle pulse on the last cycle of each ms
module ms_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [15:0] ticks_per_milli,
  output logic        ms_tick
);

  logic [15:0] cnt;
  logic [15:0] last;

  assign last    = (ticks_per_milli == 16'd0) ? 16'd0 : ticks_per_milli - 16'd1;
  // >= keeps the counter bounded if ticks_per_milli is lowered mid-count.
  assign ms_tick = !clr && (cnt >= last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr || cnt >= last) cnt <= '0;
    else                         cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/tone_scheduler.sv
// Fixed-priority, preemptive scheduler for the single tone generator.
//   clk, rst_n       : clock, async active-low reset
//   ticks_per_milli  : cycles per ms (0 behaves as 1)
//   req              : level request per requester, index 0 highest priority
//   req_melody       : 2-bit melody ID per requester, sampled at grant
//   grant            : one-hot owner, held for the whole melody
//   done / aborted   : 1-cycle pulses to the owner on completion / preemption
//   busy             : scheduler not idle
//   freq             : tone frequency in Hz, 0 = silence
module tone_scheduler
  import simon_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int GAP_MS  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          ticks_per_milli,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_melody,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   aborted,
  output logic                 busy,
  output logic [9:0]           freq
);

  localparam int         OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit         HAS_GAP  = (GAP_MS > 0);
  localparam logic [9:0] GAP_LAST = 10'(GAP_MS - 1);

  logic [2:0]         state;
  logic [OW-1:0]      owner;
  logic [1:0]         mel;
  logic [2:0]         idx;
  logic [9:0]         ms_cnt;
  logic               ms_tick;
  logic               pre_clr;
  note_t              note;

  logic               any_req;
  logic [OW-1:0]      low_idx;
  logic [1:0]         low_mel;
  logic               pre_hit;
  logic               owner_req;
  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] low_oh;

  // Lowest set request wins; scanning downwards leaves the lowest index last.
  always_comb begin
    any_req = 1'b0;
    low_idx = '0;
    low_mel = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        low_idx = OW'(i);
        low_mel = req_melody[2*i +: 2];
      end
    end
  end

  assign owner_oh  = NUM_REQ'(1) << owner;
  assign low_oh    = NUM_REQ'(1) << low_idx;
  assign owner_req = |(req & owner_oh);
  // A lower index than the owner means higher priority.
  assign pre_hit   = any_req && (low_idx < owner);
  assign note      = rom_note(mel, idx);
  assign busy      = (state != ST_IDLE);
  // Prescaler free-runs only while timing a note or a gap, so every note
  // starts from a fresh millisecond.
  assign pre_clr   = (state != ST_NOTE) && (state != ST_GAP);

  ms_prescaler u_ms (
    .clk             (clk),
    .rst_n           (rst_n),
    .clr             (pre_clr),
    .ticks_per_milli (ticks_per_milli),
    .ms_tick         (ms_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= '0;
      mel     <= '0;
      idx     <= '0;
      ms_cnt  <= '0;
      grant   <= '0;
      done    <= '0;
      aborted <= '0;
      freq    <= '0;
    end else begin
      done    <= '0;
      aborted <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner <= low_idx;
            mel   <= low_mel;
            grant <= low_oh;
            idx   <= '0;
            state <= ST_LOAD;
          end
        end
        ST_FINISH: begin
          grant <= '0;
          freq  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          // Preemption beats cancel when both happen in one cycle.
          if (pre_hit) begin
            aborted <= owner_oh;
            freq    <= '0;
            owner   <= low_idx;
            mel     <= low_mel;
            grant   <= low_oh;
            idx     <= '0;
            ms_cnt  <= '0;
            state   <= ST_LOAD;
          end else if (!owner_req) begin
            freq  <= '0;
            grant <= '0;
            state <= ST_IDLE;
          end else begin
            case (state)
              ST_LOAD: begin
                if (note.dur == 10'd0) begin
                  // done is registered here so it is visible in FINISH.
                  done  <= owner_oh;
                  state <= ST_FINISH;
                end else begin
                  freq   <= note.freq;
                  ms_cnt <= '0;
                  state  <= ST_NOTE;
                end
              end
              ST_NOTE: begin
                if (ms_tick) begin
                  if (ms_cnt == note.dur - 10'd1) begin
                    freq   <= '0;
                    ms_cnt <= '0;
                    idx    <= idx + 3'd1;
                    if (idx == 3'd7) begin
                      done  <= owner_oh;
                      state <= ST_FINISH;
                    end else begin
                      state <= HAS_GAP ? ST_GAP : ST_LOAD;
                    end
                  end else begin
                    ms_cnt <= ms_cnt + 10'd1;
                  end
                end
              end
              ST_GAP: begin
                if (ms_tick) begin
                  if (ms_cnt == GAP_LAST) begin
                    ms_cnt <= '0;
                    state  <= ST_LOAD;
                  end else begin
                    ms_cnt <= ms_cnt + 10'd1;
                  end
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler: reset state, an arbitration/cancel
// vector table, hand-written melody / preemption / gap / async-reset
// sequences, and randomized melodies compared per cycle against an expected
// frequency trace built from the melody table.
module tb_tone_scheduler;

  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [15:0]     tpm;
  logic [NR-1:0]   req_a, req_g;
  logic [2*NR-1:0] mel_a, mel_g;
  logic [NR-1:0]   grant_a, done_a, abort_a, grant_g, done_g, abort_g;
  logic            busy_a, busy_g;
  logic [9:0]      freq_a, freq_g;

  tone_scheduler #(.NUM_REQ(NR), .GAP_MS(0)) u_a (
    .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .req(req_a), .req_melody(mel_a),
    .grant(grant_a), .done(done_a), .aborted(abort_a), .busy(busy_a), .freq(freq_a)
  );

  tone_scheduler #(.NUM_REQ(NR), .GAP_MS(10)) u_g (
    .clk(clk), .rst_n(rst_n), .ticks_per_milli(tpm), .req(req_g), .req_melody(mel_g),
    .grant(grant_g), .done(done_g), .aborted(abort_g), .busy(busy_g), .freq(freq_g)
  );

  // Selected DUT view: 0 = no gap, 1 = 10 ms gap.
  logic            sel;
  logic [NR-1:0]   grant_s, done_s, abort_s;
  logic            busy_s;
  logic [9:0]      freq_s;
  always_comb begin
    grant_s = sel ? grant_g : grant_a;
    done_s  = sel ? done_g  : done_a;
    abort_s = sel ? abort_g : abort_a;
    busy_s  = sel ? busy_g  : busy_a;
    freq_s  = sel ? freq_g  : freq_a;
  end

  int checks = 0;
  int errors = 0;

  // Melody table as listed in the design description.
  int mel_n [4]    = '{6, 4, 2, 1};
  int mel_f [4][6] = '{'{330, 392, 659, 523, 587, 784},
                       '{622, 587, 554, 523, 0, 0},
                       '{196, 784, 0, 0, 0, 0},
                       '{262, 0, 0, 0, 0, 0}};
  int mel_d [4]    = '{150, 300, 100, 50};

  int exp_q[$];

  typedef struct {
    logic [NR-1:0]   req;
    logic [2*NR-1:0] mel;
    logic [NR-1:0]   exp_grant;
    int              exp_freq;
  } vec_t;
  vec_t vt [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input bit s, input logic [NR-1:0] r, input logic [2*NR-1:0] mv);
    if (s) begin req_g = r; mel_g = mv; end
    else   begin req_a = r; mel_a = mv; end
  endtask

  // Expected freq after each edge following the grant edge, up to and
  // including the cycle in which the end marker is read.
  task automatic build_trace(input int m, input int t, input int gap);
    int te;
    te = (t == 0) ? 1 : t;
    exp_q = {};
    for (int n = 0; n < mel_n[m]; n++) begin
      repeat (mel_d[m] * te)  exp_q.push_back(mel_f[m][n]);
      repeat (gap * te + 1)   exp_q.push_back(0);
    end
  endtask

  task automatic play(input bit s, input int r, input int m, input int t, input bit do_cancel);
    logic [NR-1:0]   g1;
    logic [1:0]      mm;
    logic [2*NR-1:0] mv;
    int ca, n_cyc, bad, bad_f, bad_g;
    g1  = NR'(1) << r;
    mm  = m[1:0];
    mv  = {NR{mm}};
    sel = s;
    tpm = 16'(t);
    build_trace(m, t, s ? 10 : 0);
    ca  = do_cancel ? int'($urandom_range(exp_q.size() - 1, 1)) : -1;
    set_req(s, g1, mv);
    tick();
    chk("grant at start", int'(grant_s), int'(g1));
    chk("busy at start", int'(busy_s), 1);
    // Melody ID is sampled only at grant; scramble it afterwards.
    set_req(s, g1, 6'($urandom()));
    n_cyc = (ca >= 0) ? ca : exp_q.size();
    bad = -1; bad_f = 0; bad_g = 0;
    for (int k = 0; k < n_cyc; k++) begin
      tick();
      if (bad < 0 && (int'(freq_s) != exp_q[k] || grant_s != g1 ||
                      done_s != '0 || abort_s != '0)) begin
        bad = k; bad_f = int'(freq_s); bad_g = int'(grant_s);
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL trace dut%0d mel%0d tpm%0d cyc %0d: freq %0d grant %0d, expected freq %0d grant %0d",
               s, m, t, bad, bad_f, bad_g, exp_q[bad], int'(g1));
    end
    if (ca >= 0) begin
      set_req(s, '0, '0);
      tick();
      chk("cancel outputs", int'({grant_s, done_s, abort_s, busy_s, freq_s}), 0);
    end else begin
      tick();
      chk("done pulse", int'(done_s), int'(g1));
      chk("freq at finish", int'(freq_s), 0);
      set_req(s, '0, '0);
      tick();
      chk("idle after done", int'({grant_s, done_s, busy_s, freq_s}), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; tpm = 16'd4; sel = 1'b0;
    req_a = '0; req_g = '0; mel_a = '0; mel_g = '0;

    // Reset state
    #12;
    chk("reset grant", int'(grant_a), 0);
    chk("reset done/aborted", int'({done_a, abort_a}), 0);
    chk("reset busy", int'(busy_a), 0);
    chk("reset freq", int'(freq_a), 0);
    chk("reset gap dut", int'({grant_g, done_g, abort_g, busy_g, freq_g}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Arbitration from IDLE, then cancel mid-note. mel = {mel2, mel1, mel0}.
    vt[0] = '{req: 3'b100, mel: {2'd3, 2'd0, 2'd0}, exp_grant: 3'b100, exp_freq: 262};
    vt[1] = '{req: 3'b011, mel: {2'd0, 2'd2, 2'd1}, exp_grant: 3'b001, exp_freq: 622};
    vt[2] = '{req: 3'b110, mel: {2'd3, 2'd2, 2'd0}, exp_grant: 3'b010, exp_freq: 196};
    vt[3] = '{req: 3'b111, mel: {2'd1, 2'd1, 2'd0}, exp_grant: 3'b001, exp_freq: 330};
    vt[4] = '{req: 3'b010, mel: {2'd0, 2'd3, 2'd2}, exp_grant: 3'b010, exp_freq: 262};
    vt[5] = '{req: 3'b101, mel: {2'd2, 2'd0, 2'd1}, exp_grant: 3'b001, exp_freq: 622};
    sel = 1'b0; tpm = 16'd4;
    for (int v = 0; v < 6; v++) begin
      set_req(0, vt[v].req, vt[v].mel);
      tick();
      chk($sformatf("vec%0d grant", v), int'(grant_a), int'(vt[v].exp_grant));
      chk($sformatf("vec%0d busy", v), int'(busy_a), 1);
      tick();
      chk($sformatf("vec%0d first freq", v), int'(freq_a), vt[v].exp_freq);
      repeat (3) tick();
      set_req(0, '0, '0);
      tick();
      chk($sformatf("vec%0d cancel", v), int'({grant_a, done_a, abort_a, busy_a, freq_a}), 0);
    end

    // Basic CLICK, SUCCESS sequence, GAP with zero prescaler
    play(0, 2, 3, 4, 1'b0);
    play(0, 0, 0, 2, 1'b0);
    play(1, 1, 2, 0, 1'b0);

    // Preemption: CHIME on requester 2, GAMEOVER on requester 0 20 ms in.
    sel = 1'b0; tpm = 16'd4;
    set_req(0, 3'b100, {2'd2, 2'd0, 2'd0});
    tick();
    tick();
    repeat (79) tick();
    chk("pre note playing", int'(freq_a), 196);
    set_req(0, 3'b101, {2'd2, 2'd0, 2'd1});
    tick();
    chk("pre aborted", int'(abort_a), 3'b100);
    chk("pre grant", int'(grant_a), 3'b001);
    chk("pre no done", int'(done_a), 0);
    tick();
    chk("pre new freq", int'(freq_a), 622);
    chk("pre aborted pulse width", int'(abort_a), 0);
    set_req(0, 3'b001, {2'd0, 2'd0, 2'd1});
    repeat (20) tick();
    chk("pre owner keeps playing", int'({grant_a, done_a, freq_a}), {3'b001, 3'b000, 10'd622});
    set_req(0, '0, '0);
    tick();
    chk("pre cancel", int'({grant_a, done_a, abort_a, busy_a, freq_a}), 0);

    // Async reset mid-note.
    set_req(0, 3'b100, {2'd3, 2'd0, 2'd0});
    tick();
    repeat (10) tick();
    chk("rst note playing", int'(freq_a), 262);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst outputs", int'({grant_a, done_a, abort_a, busy_a, freq_a}), 0);
    set_req(0, '0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle after rst", int'(busy_a), 0);
    set_req(0, 3'b010, {2'd0, 2'd3, 2'd0});
    tick();
    chk("grant after rst", int'(grant_a), 3'b010);
    set_req(0, '0, '0);
    tick();

    // Randomized melodies, optionally cancelled part way through.
    for (int it = 0; it < 8; it++) begin
      play(1'($urandom_range(1, 0)), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
           int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
